// File: rtl/mfrc522_pkg.sv
// rtl/mfrc522_pkg.sv - shared types and helpers for the MFRC-522 SPI register blocks
//
// Purpose : state encoding, read/write direction bit and address-byte
//           formatting shared by the register-read and register-write masters.
// Ports   : none (package).

package mfrc522_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCK_LO   = 3'd1,
        SCK_HI   = 3'd2,
        BYTE_END = 3'd3,
        CS_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    // MSB of the MFRC-522 address byte: 1 = read, 0 = write.
    localparam logic READ_BIT = 1'b1;

    // MFRC-522 address byte layout: {R/W, addr[5:0], 0}.
    function automatic logic [7:0] mfrc522_addr_byte(input logic i_rnw,
                                                     input logic [5:0] i_addr);
        return {i_rnw, i_addr, 1'b0};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCK phase timer for the MFRC-522 SPI masters
//
// Purpose : counts CLK_DIV clock cycles while enabled and flags the last
//           cycle of each phase; the count restarts at 0 after phase_end or
//           whenever the enable drops.
// Ports   : i_clk       system clock
//           i_rst       asynchronous active-high reset
//           i_en        count enable (high while a timed phase is active)
//           o_phase_end high on the last cycle of the current phase

module spi_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_phase_end
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign o_phase_end = i_en && (r_cnt == DIV_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/read_from_reg.sv
// rtl/read_from_reg.sv - SPI mode-0 master reading MFRC-522 registers
//
// Purpose : sends the read-address byte {1, addr, 0} N times followed by 0x00
//           (N = max(len,1)), shifts in N+1 MISO bytes, drops the first and
//           presents each following byte on rd_data with a rd_valid pulse.
//           Ends with a one-cycle done pulse.
// Option  : READ_FROM_REG_MISO_SYNC_EN - when defined, MISO goes through a
//           2-flop synchronizer before sampling (requires CLK_DIV >= 3).
// Ports   : clk      system clock
//           reset    asynchronous active-high reset
//           start    one-cycle request, accepted only in IDLE
//           addr     register address [5:0]
//           len      data bytes to read, 0 treated as 1
//           MISO     serial data from the MFRC-522
//           MOSI     serial data to the MFRC-522
//           SCK      SPI clock, idle low
//           SDA      chip select, active low
//           rd_data  most recently received byte
//           rd_valid one-cycle pulse when rd_data is new
//           done     one-cycle pulse at end of transaction
//           busy     high from start acceptance until done

module read_from_reg
    import mfrc522_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] addr,
    input  logic [3:0] len,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SCK,
    output logic       SDA,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       busy
);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("read_from_reg: CLK_DIV must be in 1..255");
        end
`ifdef READ_FROM_REG_MISO_SYNC_EN
        if (CLK_DIV < 3) begin : g_bad_sync_div
            $error("read_from_reg: MISO synchronizer needs CLK_DIV >= 3");
        end
`endif
    endgenerate

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_ra;        // latched read-address byte
    logic [3:0] r_n;         // number of data bytes
    logic [3:0] r_bit;       // bits shifted in the current byte, 0..8
    logic [3:0] r_byte;      // current byte index, 0..N
    logic [7:0] r_tx;        // MOSI shift register, MSB is on the wire
    logic [7:0] r_rx;        // MISO shift register

    logic       w_miso;
    logic       w_phase_end;
    logic       w_div_en;
    logic [3:0] w_bit_inc;
    logic [3:0] w_byte_inc;
    logic       w_byte_last;
    logic [7:0] w_ra;
    logic [3:0] w_n;
    logic [7:0] w_next_tx;

`ifdef READ_FROM_REG_MISO_SYNC_EN
    logic r_miso_s1;
    logic r_miso_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    assign w_miso = r_miso_s2;
`else
    assign w_miso = MISO;
`endif

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_en       (w_div_en),
        .o_phase_end(w_phase_end)
    );

    assign w_ra        = mfrc522_addr_byte(READ_BIT, addr);
    assign w_n         = (len == 4'd0) ? 4'd1 : len;
    assign w_bit_inc   = r_bit + 4'd1;
    assign w_byte_inc  = r_byte + 4'd1;
    assign w_byte_last = (r_byte == r_n);
    // The byte after the last address repeat is the 0x00 trailer that clocks
    // out the final data byte.
    assign w_next_tx   = (w_byte_inc == r_n) ? 8'h00 : r_ra;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = SCK_LO;
                end
            end
            SCK_LO: begin
                if (w_phase_end) begin
                    w_next_state = SCK_HI;
                end
            end
            SCK_HI: begin
                if (w_phase_end) begin
                    w_next_state = (w_bit_inc == 4'd8) ? BYTE_END : SCK_LO;
                end
            end
            BYTE_END: begin
                w_next_state = w_byte_last ? CS_HOLD : SCK_LO;
            end
            CS_HOLD: begin
                if (w_phase_end) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output decode: only the timed phases run the divider
    always_comb begin
        w_div_en = 1'b0;
        case (r_state)
            SCK_LO, SCK_HI, CS_HOLD: w_div_en = 1'b1;
            default:                 w_div_en = 1'b0;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MOSI     <= 1'b0;
            SCK      <= 1'b0;
            SDA      <= 1'b1;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            r_ra     <= 8'h00;
            r_n      <= 4'd0;
            r_bit    <= 4'd0;
            r_byte   <= 4'd0;
            r_tx     <= 8'h00;
            r_rx     <= 8'h00;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ra   <= w_ra;
                        r_n    <= w_n;
                        r_tx   <= w_ra;
                        MOSI   <= w_ra[7];
                        SDA    <= 1'b0;
                        busy   <= 1'b1;
                        r_bit  <= 4'd0;
                        r_byte <= 4'd0;
                    end
                end
                SCK_LO: begin
                    if (w_phase_end) begin
                        SCK <= 1'b1;
                    end
                end
                SCK_HI: begin
                    if (w_phase_end) begin
                        // Sample on the last high cycle; MOSI moves together
                        // with the falling edge so it is never changed while
                        // SCK is high.
                        SCK   <= 1'b0;
                        r_rx  <= {r_rx[6:0], w_miso};
                        r_bit <= w_bit_inc;
                        if (w_bit_inc != 4'd8) begin
                            r_tx <= {r_tx[6:0], 1'b0};
                            MOSI <= r_tx[6];
                        end
                    end
                end
                BYTE_END: begin
                    // Byte 0 arrives while the address goes out; it carries
                    // no register data.
                    if (r_byte != 4'd0) begin
                        rd_data  <= r_rx;
                        rd_valid <= 1'b1;
                    end
                    if (!w_byte_last) begin
                        r_byte <= w_byte_inc;
                        r_bit  <= 4'd0;
                        r_tx   <= w_next_tx;
                        MOSI   <= w_next_tx[7];
                    end
                end
                CS_HOLD: begin
                    if (w_phase_end) begin
                        SDA <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_from_reg.sv
// tb/tb_read_from_reg.sv - scoreboard bench for read_from_reg (CLK_DIV 1 and 4)

module tb_read_from_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sel;
    logic [5:0] addr;
    logic [3:0] len;
    logic       miso;

    logic       start1, mosi1, sck1, sda1, rv1, done1, busy1;
    logic       start4, mosi4, sck4, sda4, rv4, done4, busy4;
    logic [7:0] rd1, rd4;

    always #5 clk = ~clk;

    assign start1 = start & ~sel;
    assign start4 = start & sel;

    read_from_reg #(.CLK_DIV(1)) dut (
        .clk(clk), .reset(reset), .start(start1), .addr(addr), .len(len),
        .MISO(miso), .MOSI(mosi1), .SCK(sck1), .SDA(sda1), .rd_data(rd1),
        .rd_valid(rv1), .done(done1), .busy(busy1)
    );

    read_from_reg #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .addr(addr), .len(len),
        .MISO(miso), .MOSI(mosi4), .SCK(sck4), .SDA(sda4), .rd_data(rd4),
        .rd_valid(rv4), .done(done4), .busy(busy4)
    );

    logic       mosi_m, sck_m, sda_m, rv_m, done_m, busy_m;
    logic [7:0] rd_m;
    assign mosi_m = sel ? mosi4 : mosi1;
    assign sck_m  = sel ? sck4  : sck1;
    assign sda_m  = sel ? sda4  : sda1;
    assign rv_m   = sel ? rv4   : rv1;
    assign done_m = sel ? done4 : done1;
    assign busy_m = sel ? busy4 : busy1;
    assign rd_m   = sel ? rd4   : rd1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] slv_q[$];

    // MFRC-522 model: samples MOSI on SCK rise, shifts MISO on SCK fall.
    logic [7:0] slv_sr = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         slv_bits = 0;

    always @(negedge sda_m) begin
        slv_bits = 0;
        slv_sr   = 8'h3C;
        miso     = slv_sr[7];
    end

    always @(posedge sck_m) begin
        if (!sda_m) begin
            slv_rx = {slv_rx[6:0], mosi_m};
            slv_bits++;
            if (slv_bits == 8) begin
                if (exp_mosi_q.size() == 0) check("mosi_unexpected_byte", 32'(slv_rx), 32'h100);
                else check("mosi_byte", 32'(slv_rx), 32'(exp_mosi_q.pop_front()));
            end
        end
    end

    always @(negedge sck_m) begin
        if (!sda_m) begin
            if (slv_bits == 8) begin
                slv_bits = 0;
                slv_sr   = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
            end else begin
                slv_sr = {slv_sr[6:0], 1'b0};
            end
            miso = slv_sr[7];
        end
    end

    // Output monitor, sampled on the falling clock edge
    int   cyc = 0;
    int   t_start, t_rv, t_done, t_sda;
    int   rv_cnt, done_cnt, rise_cnt, mosi_viol, hi_bad, hi_run;
    logic prev_sck = 1'b0;
    logic prev_mosi = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (rv_m) begin
                rv_cnt++;
                if (t_rv < 0) t_rv = cyc;
                if (exp_rd_q.size() == 0) check("rd_valid_unexpected", 32'(rd_m), 32'h100);
                else check("rd_data", 32'(rd_m), 32'(exp_rd_q.pop_front()));
            end
            if (done_m) begin
                done_cnt++;
                if (t_done < 0) t_done = cyc;
            end
            if (!sda_m && t_sda < 0) t_sda = cyc;
            if (sck_m && !prev_sck) rise_cnt++;
            if (sck_m && prev_sck && (mosi_m !== prev_mosi)) mosi_viol++;
            if (sck_m) hi_run++;
            else if (prev_sck) begin
                if (hi_run != (sel ? 4 : 1)) hi_bad++;
                hi_run = 0;
            end
            prev_sck  = sck_m;
            prev_mosi = mosi_m;
        end
    end

    task automatic push_data(input logic [7:0] b);
        slv_q.push_back(b);
        exp_rd_q.push_back(b);
    endtask

    task automatic kick(input logic [5:0] a, input logic [3:0] l);
        int         n;
        logic [7:0] ra;
        n  = (l == 4'd0) ? 1 : int'(l);
        ra = {1'b1, a, 1'b0};
        for (int i = 0; i < n; i++) exp_mosi_q.push_back(ra);
        exp_mosi_q.push_back(8'h00);
        rv_cnt = 0; done_cnt = 0; rise_cnt = 0; mosi_viol = 0; hi_bad = 0; hi_run = 0;
        t_rv = -1; t_done = -1; t_sda = -1;
        @(negedge clk);
        addr    = a;
        len     = l;
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done_m && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done_m) check("done_timeout", 32'(0), 32'(1));
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_txn(input string tag, input int exp_rv, input int exp_rise);
        check({tag, "_rv_count"}, 32'(rv_cnt), 32'(exp_rv));
        check({tag, "_done_count"}, 32'(done_cnt), 32'(1));
        check({tag, "_sck_rises"}, 32'(rise_cnt), 32'(exp_rise));
        check({tag, "_mosi_q_left"}, 32'(exp_mosi_q.size()), 32'(0));
        check({tag, "_rd_q_left"}, 32'(exp_rd_q.size()), 32'(0));
        check({tag, "_sda_idle"}, 32'(sda_m), 32'(1));
        check({tag, "_busy_idle"}, 32'(busy_m), 32'(0));
        check({tag, "_mosi_stable_hi"}, 32'(mosi_viol), 32'(0));
        check({tag, "_sck_hi_len"}, 32'(hi_bad), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; addr = '0; len = '0; miso = 1'b0;
        t_start = 0; t_rv = -1; t_done = -1; t_sda = -1;
        rv_cnt = 0; done_cnt = 0; rise_cnt = 0; mosi_viol = 0; hi_bad = 0; hi_run = 0;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck1), 32'(0));
        check("rst_sda", 32'(sda1), 32'(1));
        check("rst_mosi", 32'(mosi1), 32'(0));
        check("rst_rd_data", 32'(rd1), 32'(0));
        check("rst_rd_valid", 32'(rv1), 32'(0));
        check("rst_done", 32'(done1), 32'(0));
        check("rst_busy", 32'(busy1), 32'(0));
        check("rst_sda_div4", 32'(sda4), 32'(1));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte, CLK_DIV=1, with latency
        push_data(8'h5A);
        kick(6'h04, 4'd1);
        wait_done(200);
        check_txn("len1", 1, 16);
        check("len1_sda_latency", 32'(t_sda - t_start), 32'(1));
        check("len1_rv_latency", 32'(t_rv - t_start), 32'(35));
        check("len1_done_latency", 32'(t_done - t_start), 32'(37));

        // Three bytes
        push_data(8'hA1); push_data(8'hB2); push_data(8'hC3);
        kick(6'h09, 4'd3);
        wait_done(400);
        check_txn("len3", 3, 32);

        // len=0 behaves as len=1
        push_data(8'h77);
        kick(6'h3F, 4'd0);
        wait_done(200);
        check_txn("len0", 1, 16);
        check("len0_rv_latency", 32'(t_rv - t_start), 32'(35));
        check("len0_done_latency", 32'(t_done - t_start), 32'(37));

        // CLK_DIV=4 instance
        sel = 1'b1;
        repeat (2) @(negedge clk);
        push_data(8'hC6); push_data(8'h39);
        kick(6'h12, 4'd2);
        wait_done(1000);
        check_txn("div4", 2, 24);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Start pulsed mid-transfer is ignored
        push_data(8'h11);
        kick(6'h05, 4'd1);
        repeat (10) @(negedge clk);
        addr = 6'h2A; len = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (20) @(negedge clk);
        check_txn("midstart", 1, 16);

        // Start in the DONE-state cycle is ignored
        push_data(8'h22);
        kick(6'h01, 4'd1);
        while (cyc < t_start + 36) @(negedge clk);
        addr = 6'h3A; len = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_txn("donestart", 1, 16);

        // Reset during byte 1
        push_data(8'h44);
        kick(6'h07, 4'd1);
        while (cyc < t_start + 25) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_sda", 32'(sda1), 32'(1));
        check("abort_sck", 32'(sck1), 32'(0));
        check("abort_busy", 32'(busy1), 32'(0));
        exp_mosi_q.delete();
        exp_rd_q.delete();
        slv_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("abort_no_rd_valid", 32'(rv_cnt), 32'(0));
        check("abort_no_done", 32'(done_cnt), 32'(0));

        push_data(8'h9C);
        kick(6'h04, 4'd1);
        wait_done(200);
        check_txn("after_abort", 1, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
